// File: rtl/digit_pair_ctrl.sv
// digit_pair_ctrl: two-digit BCD overlay value committed on frame_tick; DIGIT_PAIR_LZB_EN blanks a leading zero.
module digit_pair_ctrl #(
  parameter int BASE_X = 200,
  parameter int BASE_Y = 190,
  parameter int DIGIT_PITCH = 80,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       inc,
  input  logic       clr,
  input  logic       run,
  output logic [3:0] tens_code,
  output logic [3:0] ones_code,
  output logic [9:0] tens_x,
  output logic [9:0] ones_x,
  output logic [9:0] digit_y,
  output logic       wrap
);
  localparam logic [9:0] FMAX = 10'(FRAMES_PER_STEP - 1);
  logic [3:0] tens, ones, step, ones_new, tens_new;
  logic [2:0] pending;
  logic [9:0] fcnt;
  logic [4:0] ones_sum, tens_sum;
  logic       auto_step, carry, tens_wrap;
  assign tens_x  = 10'(BASE_X);
  assign ones_x  = 10'(BASE_X + DIGIT_PITCH);
  assign digit_y = 10'(BASE_Y);
  assign ones_code = ones;
  always_comb begin
    auto_step = run && (fcnt == FMAX);
    step      = {1'b0, pending} + {3'b0, auto_step};
    ones_sum  = {1'b0, ones} + {1'b0, step};
    carry     = ones_sum >= 5'd10;
    ones_new  = carry ? 4'(ones_sum - 5'd10) : ones_sum[3:0];
    tens_sum  = {1'b0, tens} + {4'b0, carry};
    tens_wrap = tens_sum >= 5'd10;
    tens_new  = tens_wrap ? 4'(tens_sum - 5'd10) : tens_sum[3:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      tens    <= '0;
      ones    <= '0;
      pending <= '0;
      fcnt    <= '0;
      wrap    <= 1'b0;
`ifdef DIGIT_PAIR_LZB_EN
      tens_code <= 4'hF;
`else
      tens_code <= 4'h0;
`endif
    end else begin
      wrap <= frame_tick && tens_wrap;
      // an inc arriving with frame_tick is held for the following frame
      pending <= frame_tick ? {2'b0, inc} : (pending == 3'd7 ? 3'd7 : pending + {2'b0, inc});
      if (frame_tick) begin
        tens <= tens_new;
        ones <= ones_new;
        if (run) fcnt <= auto_step ? '0 : fcnt + 10'd1;
`ifdef DIGIT_PAIR_LZB_EN
        tens_code <= (tens_new == 4'd0) ? 4'hF : tens_new;
`else
        tens_code <= tens_new;
`endif
      end
    end
  end
endmodule

// File: tb/tb_digit_pair_ctrl.sv
// tb_digit_pair_ctrl: directed scenarios plus randomized run against an integer value model.
module tb_digit_pair_ctrl;
  localparam int FPS = 4;
  logic clk = 0, rst_n = 0, frame_tick = 0, inc = 0, clr = 0, run = 0;
  logic [3:0] tens_code, ones_code;
  logic [9:0] tens_x, ones_x, digit_y;
  logic wrap;
  int checks = 0, errors = 0;
  int m_val = 0, m_pend = 0, m_fcnt = 0;
  logic m_wrap = 0;

  digit_pair_ctrl #(.FRAMES_PER_STEP(FPS)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .inc(inc), .clr(clr), .run(run),
    .tens_code(tens_code), .ones_code(ones_code), .tens_x(tens_x), .ones_x(ones_x),
    .digit_y(digit_y), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_tc(input int t);
`ifdef DIGIT_PAIR_LZB_EN
    return (t == 0) ? 4'hF : 4'(t);
`else
    return 4'(t);
`endif
  endfunction

  task automatic tick(input bit ft, input bit i, input bit c, input bit rn);
    int s;
    frame_tick = ft; inc = i; clr = c; rst_n = rn;
    @(posedge clk);
    if (!rn || c) begin
      m_val = 0; m_pend = 0; m_fcnt = 0; m_wrap = 0;
    end else if (ft) begin
      s = m_pend + ((run && m_fcnt == FPS - 1) ? 1 : 0);
      m_wrap = (m_val + s) >= 100;
      m_val = (m_val + s) % 100;
      if (run) m_fcnt = (m_fcnt + 1) % FPS;
      m_pend = i;
    end else begin
      m_wrap = 0;
      m_pend = (m_pend + i > 7) ? 7 : m_pend + i;
    end
    #1;
    frame_tick = 0; inc = 0; clr = 0; rst_n = 1;
  endtask

  task automatic set_value(input int v);
    int k;
    tick(0, 0, 1, 1);
    while (v > 0) begin
      k = (v > 7) ? 7 : v;
      repeat (k) tick(0, 1, 0, 1);
      tick(1, 0, 0, 1);
      v -= k;
    end
    tick(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++; if (tens_code !== exp_tc(0)) begin errors++; $display("FAIL reset_tens got %h want %h", tens_code, exp_tc(0)); end
    checks++; if (ones_code !== 4'd0) begin errors++; $display("FAIL reset_ones got %h want 0", ones_code); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
    checks++; if (tens_x !== 10'd200 || ones_x !== 10'd280 || digit_y !== 10'd190) begin
      errors++; $display("FAIL reset_pos got %0d/%0d/%0d want 200/280/190", tens_x, ones_x, digit_y); end
  endtask

  task automatic test_deferred();
    tick(0, 0, 1, 1);
    repeat (3) begin
      tick(0, 1, 0, 1);
      checks++; if (tens_code !== exp_tc(0) || ones_code !== 4'd0) begin
        errors++; $display("FAIL deferred_hold got %h/%h want %h/0", tens_code, ones_code, exp_tc(0)); end
    end
    tick(1, 0, 0, 1);
    checks++; if (tens_code !== exp_tc(0) || ones_code !== 4'd3) begin
      errors++; $display("FAIL deferred_commit got %h/%h want %h/3", tens_code, ones_code, exp_tc(0)); end
  endtask

  task automatic test_carry_wrap();
    set_value(97);
    checks++; if (tens_code !== exp_tc(9) || ones_code !== 4'd7) begin
      errors++; $display("FAIL preset97 got %h/%h want 9/7", tens_code, ones_code); end
    repeat (5) tick(0, 1, 0, 1);
    tick(1, 0, 0, 1);
    checks++; if (tens_code !== exp_tc(0) || ones_code !== 4'd2 || wrap !== 1'b1) begin
      errors++; $display("FAIL wrap_commit got %h/%h w%b want %h/2 w1", tens_code, ones_code, wrap, exp_tc(0)); end
    tick(0, 0, 0, 1);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %b want 0", wrap); end
    set_value(45);
    repeat (7) tick(0, 1, 0, 1);
    tick(1, 0, 0, 1);
    checks++; if (tens_code !== exp_tc(5) || ones_code !== 4'd2 || wrap !== 1'b0) begin
      errors++; $display("FAIL carry52 got %h/%h w%b want 5/2 w0", tens_code, ones_code, wrap); end
  endtask

  task automatic test_saturation();
    tick(0, 0, 1, 1);
    repeat (10) tick(0, 1, 0, 1);
    tick(1, 1, 0, 1);
    checks++; if (tens_code !== exp_tc(0) || ones_code !== 4'd7) begin
      errors++; $display("FAIL sat7 got %h/%h want %h/7", tens_code, ones_code, exp_tc(0)); end
    tick(1, 0, 0, 1);
    checks++; if (tens_code !== exp_tc(0) || ones_code !== 4'd8) begin
      errors++; $display("FAIL coincide got %h/%h want %h/8", tens_code, ones_code, exp_tc(0)); end
  endtask

  task automatic test_auto_run();
    tick(0, 0, 1, 1);
    run = 1;
    repeat (8) tick(1, 0, 0, 1);
    checks++; if (tens_code !== exp_tc(0) || ones_code !== 4'd2) begin
      errors++; $display("FAIL auto8 got %h/%h want %h/2", tens_code, ones_code, exp_tc(0)); end
    run = 0;
    repeat (3) tick(1, 0, 0, 1);
    checks++; if (ones_code !== 4'd2) begin errors++; $display("FAIL run_off got %h want 2", ones_code); end
    run = 1;
    repeat (3) tick(1, 0, 0, 1);
    checks++; if (ones_code !== 4'd2) begin errors++; $display("FAIL fcnt_held3 got %h want 2", ones_code); end
    tick(1, 0, 0, 1);
    checks++; if (ones_code !== 4'd3) begin errors++; $display("FAIL fcnt_held4 got %h want 3", ones_code); end
    run = 0;
  endtask

  task automatic test_clear_priority();
    set_value(23);
    repeat (4) tick(0, 1, 0, 1);
    tick(1, 0, 1, 1);
    checks++; if (tens_code !== exp_tc(0) || ones_code !== 4'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL clr_commit got %h/%h w%b want %h/0 w0", tens_code, ones_code, wrap, exp_tc(0)); end
    tick(1, 0, 0, 1);
    checks++; if (tens_code !== exp_tc(0) || ones_code !== 4'd0) begin
      errors++; $display("FAIL clr_pending got %h/%h want %h/0", tens_code, ones_code, exp_tc(0)); end
  endtask

  task automatic test_random();
    tick(0, 0, 1, 1);
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) run = $urandom_range(0, 1);
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 150) == 0, $urandom_range(0, 300) != 0);
      checks++; if (tens_code !== exp_tc(m_val / 10) || ones_code !== 4'(m_val % 10) || wrap !== m_wrap) begin
        errors++; $display("FAIL random n=%0d got %h/%h w%b want %h/%0d w%b", n, tens_code, ones_code, wrap,
                           exp_tc(m_val / 10), m_val % 10, m_wrap); end
    end
    run = 0;
  endtask

  initial begin
    test_reset();
    test_deferred();
    test_carry_wrap();
    test_saturation();
    test_auto_run();
    test_clear_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
